// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM/UART port controller.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_STAT   = 3'd4,
        ST_TXWAIT = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        TGT_RAM  = 2'd0,
        TGT_UART = 2'd1,
        TGT_STAT = 2'd2
    } tgt_e;

    localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

    // Bit positions inside the UART status word returned on a status read
    localparam int STAT_TX_IDLE_BIT  = 0;
    localparam int STAT_RX_READY_BIT = 1;

    // Index of each UART status input in the synchroniser bank
    localparam int SYNC_N      = 3;
    localparam int SYNC_TBRE   = 0;
    localparam int SYNC_TSRE   = 1;
    localparam int SYNC_DREADY = 2;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mem_port_arbiter_ctrl.sv
// MEM-stage port controller: one request at a time to async SRAM or a
// memory-mapped UART, with registered strobes and programmable wait states.
module mem_port_arbiter_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter int                DATA_W         = 16,
    parameter int                RAM_ADDR_W     = 18,
    parameter int                WAIT_CYCLES    = 1,
    parameter logic [ADDR_W-1:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
    parameter logic [ADDR_W-1:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
    parameter bit                UART_TX_BLOCK  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  ram_en,
    output logic                  ram_oe,
    output logic                  ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_dq_o,
    output logic                  ram_dq_oe,
    input  logic [DATA_W-1:0]     ram_dq_i,
    input  logic                  tbre,
    input  logic                  tsre,
    input  logic                  data_ready,
    output logic                  rdn,
    output logic                  wrn
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    logic [SYNC_N-1:0] stat_raw;
    logic [SYNC_N-1:0] stat_s;

    assign stat_raw[SYNC_TBRE]   = tbre;
    assign stat_raw[SYNC_TSRE]   = tsre;
    assign stat_raw[SYNC_DREADY] = data_ready;

    generate
        for (genvar gi = 0; gi < SYNC_N; gi++) begin : g_sync
            sync2 u_sync (
                .clk (CLK),
                .rst (RST),
                .d   (stat_raw[gi]),
                .q   (stat_s[gi])
            );
        end
    endgenerate

    state_e                state_q, state_d;
    tgt_e                  tgt_q, tgt_d;
    logic                  write_q, write_d;
    logic [RAM_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_oe_q, ram_oe_d;
    logic                  ram_we_q, ram_we_d;
    logic                  rdn_q, rdn_d;
    logic                  wrn_q, wrn_d;
    logic                  dq_oe_q, dq_oe_d;

    logic              accept;
    logic              tx_idle_s;
    tgt_e              req_tgt;
    logic [DATA_W-1:0] status_word;
    logic              busy_d;
    logic              strobe_d;

    always_comb begin
        accept    = req_valid && (state_q == ST_IDLE);
        tx_idle_s = stat_s[SYNC_TBRE] && stat_s[SYNC_TSRE];

        status_word                    = '0;
        status_word[STAT_TX_IDLE_BIT]  = tx_idle_s;
        status_word[STAT_RX_READY_BIT] = stat_s[SYNC_DREADY];

        if (req_addr == UART_STAT_ADDR) begin
            req_tgt = TGT_STAT;
        end else if (req_addr == UART_DATA_ADDR) begin
            req_tgt = TGT_UART;
        end else begin
            req_tgt = TGT_RAM;
        end
    end

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tgt_d   = req_tgt;
                    write_d = req_write;
                    addr_d  = RAM_ADDR_W'(req_addr);
                    wdata_d = req_wdata;
                    if (req_tgt == TGT_STAT) begin
                        state_d     = ST_STAT;
                        rsp_rdata_d = req_write ? '0 : status_word;
                    end else if (UART_TX_BLOCK && req_tgt == TGT_UART &&
                                 req_write && !tx_idle_s) begin
                        state_d = ST_TXWAIT;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_TXWAIT: begin
                if (tx_idle_s) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
            end
            ST_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d     = ST_HOLD;
                    rsp_rdata_d = write_q ? '0 : ram_dq_i;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HOLD:  state_d = ST_IDLE;
            ST_STAT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Pin levels are decoded from the upcoming state so they come straight off flops
        busy_d   = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
        strobe_d = (state_d == ST_ACCESS);

        ram_en_d    = !(busy_d && tgt_d == TGT_RAM);
        ram_oe_d    = !(strobe_d && tgt_d == TGT_RAM && !write_d);
        ram_we_d    = !(strobe_d && tgt_d == TGT_RAM && write_d);
        rdn_d       = !(strobe_d && tgt_d == TGT_UART && !write_d);
        wrn_d       = !(strobe_d && tgt_d == TGT_UART && write_d);
        dq_oe_d     = busy_d && write_d;
        rsp_valid_d = (state_d == ST_HOLD) || (state_d == ST_STAT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            tgt_q       <= TGT_RAM;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ram_en_q    <= 1'b1;
            ram_oe_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            rdn_q       <= 1'b1;
            wrn_q       <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_en_q    <= ram_en_d;
            ram_oe_q    <= ram_oe_d;
            ram_we_q    <= ram_we_d;
            rdn_q       <= rdn_d;
            wrn_q       <= wrn_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_oe    = ram_oe_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = addr_q;
    assign ram_dq_o  = wdata_q;
    assign ram_dq_oe = dq_oe_q;
    assign rdn       = rdn_q;
    assign wrn       = wrn_q;

endmodule

// File: tb/tb_mem_port_arbiter_ctrl.sv
// Directed bench: dut_a has one wait state and blocking UART TX, dut_b has no wait states.
module tb_mem_port_arbiter_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] ram_dq_i = '0;
    logic        tbre = 1'b0, tsre = 1'b0, data_ready = 1'b0;

    logic        a_req_valid = 1'b0, a_req_write = 1'b0;
    logic [15:0] a_req_addr = '0, a_req_wdata = '0;
    logic        a_req_ready, a_rsp_valid, a_ram_en, a_ram_oe, a_ram_we, a_ram_dq_oe, a_rdn, a_wrn;
    logic [15:0] a_rsp_rdata, a_ram_dq_o;
    logic [17:0] a_ram_addr;

    logic        b_req_valid = 1'b0, b_req_write = 1'b0;
    logic [15:0] b_req_addr = '0, b_req_wdata = '0;
    logic        b_req_ready, b_rsp_valid, b_ram_en, b_ram_oe, b_ram_we, b_ram_dq_oe, b_rdn, b_wrn;
    logic [15:0] b_rsp_rdata, b_ram_dq_o;
    logic [17:0] b_ram_addr;

    int n_vec = 0;
    int n_err = 0;
    int strobe_viol = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter_ctrl #(
        .WAIT_CYCLES   (1),
        .UART_TX_BLOCK (1'b1)
    ) dut_a (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (a_req_valid),
        .req_write  (a_req_write),
        .req_addr   (a_req_addr),
        .req_wdata  (a_req_wdata),
        .req_ready  (a_req_ready),
        .rsp_valid  (a_rsp_valid),
        .rsp_rdata  (a_rsp_rdata),
        .ram_en     (a_ram_en),
        .ram_oe     (a_ram_oe),
        .ram_we     (a_ram_we),
        .ram_addr   (a_ram_addr),
        .ram_dq_o   (a_ram_dq_o),
        .ram_dq_oe  (a_ram_dq_oe),
        .ram_dq_i   (ram_dq_i),
        .tbre       (tbre),
        .tsre       (tsre),
        .data_ready (data_ready),
        .rdn        (a_rdn),
        .wrn        (a_wrn)
    );

    mem_port_arbiter_ctrl #(
        .WAIT_CYCLES   (0),
        .UART_TX_BLOCK (1'b0)
    ) dut_b (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (b_req_valid),
        .req_write  (b_req_write),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .req_ready  (b_req_ready),
        .rsp_valid  (b_rsp_valid),
        .rsp_rdata  (b_rsp_rdata),
        .ram_en     (b_ram_en),
        .ram_oe     (b_ram_oe),
        .ram_we     (b_ram_we),
        .ram_addr   (b_ram_addr),
        .ram_dq_o   (b_ram_dq_o),
        .ram_dq_oe  (b_ram_dq_oe),
        .ram_dq_i   (ram_dq_i),
        .tbre       (tbre),
        .tsre       (tsre),
        .data_ready (data_ready),
        .rdn        (b_rdn),
        .wrn        (b_wrn)
    );

    // At most one of oe/we/rdn/wrn may be low on either instance
    always @(negedge CLK) begin
        if (!RST) begin
            if ($countones({~a_ram_oe, ~a_ram_we, ~a_rdn, ~a_wrn}) > 1) strobe_viol <= strobe_viol + 1;
            if ($countones({~b_ram_oe, ~b_ram_we, ~b_rdn, ~b_wrn}) > 1) strobe_viol <= strobe_viol + 1;
        end
    end

    // Runs one dut_a request from an idle cycle and reports what the pins did
    task automatic a_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         input int ncyc, output int rsp_cyc, output logic [15:0] rsp_dat,
                         output int oe_lo, output int we_lo, output int rdn_lo,
                         output int en_lo, output logic [17:0] addr_k1);
        rsp_cyc = -1; rsp_dat = '0; oe_lo = 0; we_lo = 0; rdn_lo = 0; en_lo = 0; addr_k1 = '0;
        @(negedge CLK);
        a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge CLK);
            a_req_valid = 1'b0;
            if (k == 1) addr_k1 = a_ram_addr;
            if (a_ram_oe === 1'b0) oe_lo++;
            if (a_ram_we === 1'b0) we_lo++;
            if (a_rdn === 1'b0) rdn_lo++;
            if (a_ram_en === 1'b0) en_lo++;
            if (a_rsp_valid === 1'b1 && rsp_cyc < 0) begin
                rsp_cyc = k;
                rsp_dat = a_rsp_rdata;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        n_vec++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b expected 1", a_req_ready); end
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", a_rsp_valid); end
        n_vec++; if (a_rsp_rdata !== 16'h0000) begin n_err++; $display("FAIL reset_rsp_rdata: got %h expected 0000", a_rsp_rdata); end
        n_vec++; if ({a_ram_en, a_ram_oe, a_ram_we, a_rdn, a_wrn} !== 5'b11111) begin
            n_err++; $display("FAIL reset_strobes: got %b expected 11111", {a_ram_en, a_ram_oe, a_ram_we, a_rdn, a_wrn}); end
        n_vec++; if (a_ram_dq_oe !== 1'b0) begin n_err++; $display("FAIL reset_dq_oe: got %b expected 0", a_ram_dq_oe); end
        n_vec++; if (a_ram_addr !== 18'h0) begin n_err++; $display("FAIL reset_ram_addr: got %h expected 00000", a_ram_addr); end
        n_vec++; if (b_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_b_req_ready: got %b expected 1", b_req_ready); end
        RST = 1'b0;
        @(negedge CLK);
        $display("reset: done");
    endtask

    task automatic test_ram_read();
        int rc, oe, we, rd, en; logic [15:0] dat; logic [17:0] ad;
        ram_dq_i = 16'hBEEF;
        a_txn(1'b0, 16'h0123, 16'h0000, 8, rc, dat, oe, we, rd, en, ad);
        $display("ram_read: addr=%h rsp_cyc=%0d data=%h oe_low=%0d", ad, rc, dat, oe);
        n_vec++; if (ad !== 18'h00123) begin n_err++; $display("FAIL ram_read_addr: got %h expected 00123", ad); end
        n_vec++; if (oe !== 2) begin n_err++; $display("FAIL ram_read_oe_width: got %0d expected 2", oe); end
        n_vec++; if (rc !== 4) begin n_err++; $display("FAIL ram_read_latency: got %0d expected 4", rc); end
        n_vec++; if (dat !== 16'hBEEF) begin n_err++; $display("FAIL ram_read_data: got %h expected beef", dat); end
        n_vec++; if (en !== 4) begin n_err++; $display("FAIL ram_read_en_width: got %0d expected 4", en); end
        n_vec++; if (we !== 0) begin n_err++; $display("FAIL ram_read_we: got %0d expected 0", we); end
    endtask

    task automatic test_ram_write_w0();
        int we_lo, dq_ok, rc; logic dq_oe_k4; logic [15:0] dat; logic [17:0] ad;
        we_lo = 0; dq_ok = 0; rc = -1; dq_oe_k4 = 1'bx; dat = 'x; ad = '0;
        @(negedge CLK);
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 16'h0010; b_req_wdata = 16'h5A5A;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            b_req_valid = 1'b0;
            if (k == 1) ad = b_ram_addr;
            if (k == 4) dq_oe_k4 = b_ram_dq_oe;
            if (b_ram_we === 1'b0) we_lo++;
            if (k <= 3 && b_ram_dq_oe === 1'b1 && b_ram_dq_o === 16'h5A5A) dq_ok++;
            if (b_rsp_valid === 1'b1 && rc < 0) begin rc = k; dat = b_rsp_rdata; end
        end
        $display("ram_write_w0: addr=%h we_low=%0d dq_cycles=%0d rsp_cyc=%0d", ad, we_lo, dq_ok, rc);
        n_vec++; if (ad !== 18'h00010) begin n_err++; $display("FAIL wr_addr: got %h expected 00010", ad); end
        n_vec++; if (we_lo !== 1) begin n_err++; $display("FAIL wr_we_width: got %0d expected 1", we_lo); end
        n_vec++; if (dq_ok !== 3) begin n_err++; $display("FAIL wr_dq_drive: got %0d expected 3", dq_ok); end
        n_vec++; if (dq_oe_k4 !== 1'b0) begin n_err++; $display("FAIL wr_dq_release: got %b expected 0", dq_oe_k4); end
        n_vec++; if (rc !== 3) begin n_err++; $display("FAIL wr_latency: got %0d expected 3", rc); end
        n_vec++; if (dat !== 16'h0000) begin n_err++; $display("FAIL wr_rsp_rdata: got %h expected 0000", dat); end
    endtask

    task automatic test_status();
        int rc, oe, we, rd, en; logic [15:0] dat; logic [17:0] ad;
        tbre = 1'b1; tsre = 1'b1; data_ready = 1'b1;
        repeat (3) @(negedge CLK);
        a_txn(1'b0, 16'hBF01, 16'h0000, 3, rc, dat, oe, we, rd, en, ad);
        $display("status_read_11: rsp_cyc=%0d data=%h", rc, dat);
        n_vec++; if (rc !== 1) begin n_err++; $display("FAIL stat_latency: got %0d expected 1", rc); end
        n_vec++; if (dat !== 16'h0003) begin n_err++; $display("FAIL stat_word_3: got %h expected 0003", dat); end
        n_vec++; if ((en + oe + we + rd) !== 0) begin n_err++; $display("FAIL stat_no_strobe: got %0d expected 0", en + oe + we + rd); end
        data_ready = 1'b0;
        repeat (3) @(negedge CLK);
        a_txn(1'b0, 16'hBF01, 16'h0000, 3, rc, dat, oe, we, rd, en, ad);
        $display("status_read_01: rsp_cyc=%0d data=%h", rc, dat);
        n_vec++; if (dat !== 16'h0001) begin n_err++; $display("FAIL stat_word_1: got %h expected 0001", dat); end
        a_txn(1'b1, 16'hBF01, 16'hFFFF, 3, rc, dat, oe, we, rd, en, ad);
        $display("status_write: rsp_cyc=%0d data=%h", rc, dat);
        n_vec++; if (rc !== 1) begin n_err++; $display("FAIL stat_wr_latency: got %0d expected 1", rc); end
        n_vec++; if (dat !== 16'h0000) begin n_err++; $display("FAIL stat_wr_data: got %h expected 0000", dat); end
    endtask

    task automatic test_uart_read();
        int rc, oe, we, rd, en; logic [15:0] dat; logic [17:0] ad;
        ram_dq_i = 16'h0077;
        a_txn(1'b0, 16'hBF00, 16'h0000, 6, rc, dat, oe, we, rd, en, ad);
        $display("uart_read: rsp_cyc=%0d data=%h rdn_low=%0d", rc, dat, rd);
        n_vec++; if (rd !== 2) begin n_err++; $display("FAIL uart_rd_rdn_width: got %0d expected 2", rd); end
        n_vec++; if (rc !== 4) begin n_err++; $display("FAIL uart_rd_latency: got %0d expected 4", rc); end
        n_vec++; if (dat !== 16'h0077) begin n_err++; $display("FAIL uart_rd_data: got %h expected 0077", dat); end
        n_vec++; if ((en + oe) !== 0) begin n_err++; $display("FAIL uart_rd_ram_idle: got %0d expected 0", en + oe); end
    endtask

    task automatic test_uart_tx_block();
        int wrn_early, ready_bad, wrn_lo, first_lo, dq_bad, rc, en_bad;
        wrn_early = 0; ready_bad = 0; wrn_lo = 0; first_lo = -1; dq_bad = 0; rc = -1; en_bad = 0;
        tbre = 1'b1; tsre = 1'b0;
        repeat (3) @(negedge CLK);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 16'hBF00; a_req_wdata = 16'h0041;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            if (k == 1) a_req_valid = 1'b0;
            if (k <= 5) begin
                if (a_wrn !== 1'b1) wrn_early++;
                if (a_req_ready !== 1'b0) ready_bad++;
            end
            if (k == 5) tsre = 1'b1;
            if (a_wrn === 1'b0) begin
                wrn_lo++;
                if (first_lo < 0) first_lo = k;
                if (a_ram_dq_o !== 16'h0041 || a_ram_dq_oe !== 1'b1) dq_bad++;
            end
            if (a_ram_en !== 1'b1) en_bad++;
            if (a_rsp_valid === 1'b1 && rc < 0) rc = k;
        end
        $display("uart_tx_block: first_wrn_low=%0d wrn_low=%0d rsp_cyc=%0d", first_lo, wrn_lo, rc);
        n_vec++; if (wrn_early !== 0) begin n_err++; $display("FAIL tx_wrn_while_busy: got %0d expected 0", wrn_early); end
        n_vec++; if (ready_bad !== 0) begin n_err++; $display("FAIL tx_ready_while_wait: got %0d expected 0", ready_bad); end
        n_vec++; if (first_lo !== 9) begin n_err++; $display("FAIL tx_wrn_start: got %0d expected 9", first_lo); end
        n_vec++; if (wrn_lo !== 2) begin n_err++; $display("FAIL tx_wrn_width: got %0d expected 2", wrn_lo); end
        n_vec++; if (dq_bad !== 0) begin n_err++; $display("FAIL tx_dq: got %0d expected 0", dq_bad); end
        n_vec++; if (rc !== 11) begin n_err++; $display("FAIL tx_latency: got %0d expected 11", rc); end
        n_vec++; if (en_bad !== 0) begin n_err++; $display("FAIL tx_ram_en: got %0d expected 0", en_bad); end
    endtask

    task automatic test_back_to_back();
        int r1, r2, acc2, extra, busy; logic [15:0] d1, d2;
        r1 = -1; r2 = -1; acc2 = -1; extra = 0; busy = 0; d1 = 'x; d2 = 'x;
        ram_dq_i = 16'h1111;
        @(negedge CLK);
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 16'h0200;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (a_rsp_valid === 1'b1 && r1 < 0) begin
                r1 = k; d1 = a_rsp_rdata; ram_dq_i = 16'h2222;
            end else if (a_rsp_valid === 1'b1 && r2 < 0) begin
                r2 = k; d2 = a_rsp_rdata;
            end
            if (a_req_valid && a_req_ready === 1'b1) begin
                if (acc2 < 0) acc2 = k; else extra++;
            end
            if (acc2 < 0 && a_req_ready === 1'b0) busy++;
            if (acc2 >= 0 && k > acc2) a_req_valid = 1'b0;
        end
        $display("back_to_back: rsp1=%0d d1=%h accept2=%0d rsp2=%0d d2=%h", r1, d1, acc2, r2, d2);
        n_vec++; if (busy !== 4) begin n_err++; $display("FAIL b2b_busy_ready: got %0d expected 4", busy); end
        n_vec++; if (r1 !== 4) begin n_err++; $display("FAIL b2b_rsp1: got %0d expected 4", r1); end
        n_vec++; if (d1 !== 16'h1111) begin n_err++; $display("FAIL b2b_data1: got %h expected 1111", d1); end
        n_vec++; if (acc2 !== 5) begin n_err++; $display("FAIL b2b_accept2: got %0d expected 5", acc2); end
        n_vec++; if (r2 !== 9) begin n_err++; $display("FAIL b2b_rsp2: got %0d expected 9", r2); end
        n_vec++; if (d2 !== 16'h2222) begin n_err++; $display("FAIL b2b_data2: got %h expected 2222", d2); end
        n_vec++; if (extra !== 0) begin n_err++; $display("FAIL b2b_extra_accept: got %0d expected 0", extra); end
    endtask

    task automatic test_reset_mid_access();
        int rsp_seen;
        rsp_seen = 0;
        @(negedge CLK);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 16'h0040; a_req_wdata = 16'h1234;
        @(negedge CLK);
        a_req_valid = 1'b0;
        @(negedge CLK);
        n_vec++; if (a_ram_we !== 1'b0) begin n_err++; $display("FAIL rst_mid_we_active: got %b expected 0", a_ram_we); end
        #2 RST = 1'b1;
        #1;
        $display("reset_mid_access: we=%b dq_oe=%b ready=%b", a_ram_we, a_ram_dq_oe, a_req_ready);
        n_vec++; if (a_ram_we !== 1'b1) begin n_err++; $display("FAIL rst_mid_we: got %b expected 1", a_ram_we); end
        n_vec++; if (a_ram_dq_oe !== 1'b0) begin n_err++; $display("FAIL rst_mid_dq_oe: got %b expected 0", a_ram_dq_oe); end
        n_vec++; if (a_ram_en !== 1'b1) begin n_err++; $display("FAIL rst_mid_en: got %b expected 1", a_ram_en); end
        n_vec++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_idle: got %b expected 1", a_req_ready); end
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (k == 1) RST = 1'b0;
            if (a_rsp_valid !== 1'b0) rsp_seen++;
        end
        n_vec++; if (rsp_seen !== 0) begin n_err++; $display("FAIL rst_mid_no_rsp: got %0d expected 0", rsp_seen); end
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_ram_write_w0();
        test_status();
        test_uart_read();
        test_uart_tx_block();
        test_back_to_back();
        test_reset_mid_access();
        n_vec++; if (strobe_viol !== 0) begin n_err++; $display("FAIL strobe_exclusive: got %0d expected 0", strobe_viol); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
